// File: rtl/stack_pkg.sv
// Shared encodings and defaults for the stack controller.
package stack_pkg;

   localparam int DATA_W_DEF = 8;
   localparam int DEPTH_DEF  = 8;

   localparam logic [1:0] OP_NOP  = 2'b00;
   localparam logic [1:0] OP_PUSH = 2'b01;
   localparam logic [1:0] OP_POP  = 2'b10;
   localparam logic [1:0] OP_TOS  = 2'b11;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

endpackage

// File: rtl/stack_mem.sv
// DEPTH x DATA_W stack storage: one synchronous write port, one asynchronous read port.
module stack_mem #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 8
) (
   input  logic                     clk,
   input  logic                     we_i,
   input  logic [$clog2(DEPTH)-1:0] waddr_i,
   input  logic [DATA_W-1:0]        wdata_i,
   input  logic [$clog2(DEPTH)-1:0] raddr_i,
   output logic [DATA_W-1:0]        rdata_o
);

   logic [DATA_W-1:0] mem_q [DEPTH];

   // NOTE: storage arrays get no reset; a reset would turn the array into
   // flops with a huge reset fan-out and nothing ever reads an unwritten slot.
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/stack_ctrl.sv
// Three-phase (IDLE/EXEC/RESP) LIFO stack controller with push/pop/peek commands.
// Define STACK_ERR_TRAP_EN to make an illegal command set a sticky err that turns later commands into NOPs.
module stack_ctrl
   import stack_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cmd_valid,
   output logic                     cmd_ready,
   input  logic [1:0]               cmd_op,
   input  logic [DATA_W-1:0]        cmd_data,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     err
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
   localparam logic [LW-1:0] SP_FULL = LW'(DEPTH);

   logic [1:0]        state_q, state_d;
   logic [1:0]        op_q;
   logic [DATA_W-1:0] data_q;
   logic [LW-1:0]     sp_q, sp_d, sp_dec;
   logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
   logic              err_q;
   logic              exec, illegal, trap, mem_we;
   logic [DATA_W-1:0] rd_data;

   assign full      = (sp_q == SP_FULL);
   assign empty     = (sp_q == '0);
   assign level     = sp_q;
   assign cmd_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_data  = rsp_data_q;
   assign exec      = (state_q == ST_EXEC);
   assign sp_dec    = sp_q - LW'(1);

   assign illegal = ((op_q == OP_PUSH) && full) ||
                    (((op_q == OP_POP) || (op_q == OP_TOS)) && empty);

`ifdef STACK_ERR_TRAP_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)                err_q <= 1'b0;
      else if (exec && illegal) err_q <= 1'b1;
   end
`else
   assign err_q = 1'b0;
`endif

   assign err  = err_q;
   assign trap = err_q;

   // NOTE: every output of this block gets a default first, so no path leaves
   // a variable unassigned and no latch is inferred.
   always_comb begin
      state_d    = state_q;
      sp_d       = sp_q;
      rsp_data_d = rsp_data_q;
      mem_we     = 1'b0;
      case (state_q)
         ST_IDLE: if (cmd_valid) state_d = ST_EXEC;
         ST_EXEC: state_d = ST_RESP;
         default: state_d = ST_IDLE;
      endcase
      if (exec) begin
         if (trap || illegal) begin
            rsp_data_d = '0;
         end else begin
            case (op_q)
               OP_PUSH: begin
                  mem_we = 1'b1;
                  sp_d   = sp_q + LW'(1);
               end
               OP_POP: begin
                  rsp_data_d = rd_data;
                  sp_d       = sp_dec;
               end
               OP_TOS:  rsp_data_d = rd_data;
               default: ;
            endcase
         end
      end
   end

   // NOTE: state registers use non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         sp_q       <= '0;
         rsp_data_q <= '0;
         op_q       <= OP_NOP;
         data_q     <= '0;
      end else begin
         state_q    <= state_d;
         sp_q       <= sp_d;
         rsp_data_q <= rsp_data_d;
         if (cmd_valid && cmd_ready) begin
            op_q   <= cmd_op;
            data_q <= cmd_data;
         end
      end
   end

   stack_mem #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk     (clk),
      .we_i    (mem_we),
      .waddr_i (sp_q[AW-1:0]),
      .wdata_i (data_q),
      .raddr_i (sp_dec[AW-1:0]),
      .rdata_o (rd_data)
   );

endmodule

// File: tb/tb_stack_ctrl.sv
// Self-checking bench for stack_ctrl: a reference stack model fills a scoreboard at command acceptance.
module tb_stack_ctrl;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int LW     = $clog2(DEPTH) + 1;

   localparam logic [1:0] NOP  = 2'b00;
   localparam logic [1:0] PUSH = 2'b01;
   localparam logic [1:0] POP  = 2'b10;
   localparam logic [1:0] TOS  = 2'b11;

`ifdef STACK_ERR_TRAP_EN
   localparam bit TRAP_EN = 1'b1;
`else
   localparam bit TRAP_EN = 1'b0;
`endif

   typedef struct {
      logic [DATA_W-1:0] data;
      logic [LW-1:0]     level;
      logic              err;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic              cmd_valid = 1'b0;
   logic              cmd_ready;
   logic [1:0]        cmd_op = 2'b00;
   logic [DATA_W-1:0] cmd_data = '0;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_data;
   logic              full, empty, err;
   logic [LW-1:0]     level;

   int checks = 0;
   int errors = 0;

   exp_t              exp_q[$];
   logic [DATA_W-1:0] m_mem [DEPTH];
   int                m_sp;
   logic              m_err;
   logic [DATA_W-1:0] m_rsp;

   stack_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .full      (full),
      .empty     (empty),
      .level     (level),
      .err       (err)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      m_sp  = 0;
      m_err = 1'b0;
      m_rsp = '0;
      exp_q.delete();
   endtask

   task automatic model_cmd(input logic [1:0] op, input logic [DATA_W-1:0] d);
      exp_t e;
      bit   ill;
      ill = (op == PUSH && m_sp == DEPTH) || ((op == POP || op == TOS) && m_sp == 0);
      if (TRAP_EN && m_err) begin
         m_rsp = '0;
      end else if (ill) begin
         m_rsp = '0;
         if (TRAP_EN) m_err = 1'b1;
      end else begin
         case (op)
            PUSH: begin m_mem[m_sp] = d; m_sp++; end
            POP:  begin m_sp--; m_rsp = m_mem[m_sp]; end
            TOS:  m_rsp = m_mem[m_sp-1];
            default: ;
         endcase
      end
      e.data  = m_rsp;
      e.level = LW'(m_sp);
      e.err   = m_err;
      exp_q.push_back(e);
   endtask

   task automatic compare_rsp(input string name);
      exp_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL %s unexpected_rsp: rsp_data=%h with empty scoreboard", name, rsp_data);
         return;
      end
      e = exp_q.pop_front();
      if (rsp_data !== e.data || level !== e.level || err !== e.err) begin
         errors++;
         $display("FAIL %s rsp: got data=%h level=%0d err=%b, expected data=%h level=%0d err=%b",
                  name, rsp_data, level, err, e.data, e.level, e.err);
      end
   endtask

   // Issue one command from a negedge, check its latency and response, end on a negedge.
   task automatic do_cmd(input string name, input logic [1:0] op, input logic [DATA_W-1:0] d);
      int  n;
      bit  seen;
      n = 0;
      while (cmd_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s ready_timeout: cmd_ready=%b expected 1", name, cmd_ready);
         return;
      end
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_data  = d;
      @(posedge clk);
      model_cmd(op, d);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = ~d;
      seen = 1'b0;
      for (int c = 1; c <= 6 && !seen; c++) begin
         @(negedge clk);
         if (c <= 2) begin
            checks++;
            if (cmd_ready !== 1'b0) begin
               errors++;
               $display("FAIL %s ready_busy: cmd_ready=%b in cycle %0d expected 0", name, cmd_ready, c);
            end
         end
         if (rsp_valid === 1'b1) begin
            seen = 1'b1;
            checks++;
            if (c != 2) begin
               errors++;
               $display("FAIL %s latency: rsp_valid after %0d cycles expected 2", name, c);
            end
            compare_rsp(name);
         end
      end
      if (!seen) begin
         checks++;
         errors++;
         $display("FAIL %s rsp_timeout: no rsp_valid, expected one pulse", name);
         void'(exp_q.pop_front());
         return;
      end
      @(negedge clk);
      checks++;
      if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL %s after_rsp: rsp_valid=%b cmd_ready=%b expected 0 and 1", name, rsp_valid, cmd_ready);
      end
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1;
      cmd_valid = 1'b0;
      model_reset();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (cmd_ready !== 1'b1 || empty !== 1'b1 || full !== 1'b0 || level !== '0 ||
          err !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== '0) begin
         errors++;
         $display("FAIL reset_state: ready=%b empty=%b full=%b level=%0d err=%b rsp_valid=%b rsp_data=%h expected 1 1 0 0 0 0 00",
                  cmd_ready, empty, full, level, err, rsp_valid, rsp_data);
      end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_push_latency();
      do_cmd("push_3a", PUSH, 8'h3A);
      checks++;
      if (level !== LW'(1) || empty !== 1'b0) begin
         errors++;
         $display("FAIL push_3a_flags: level=%0d empty=%b expected 1 0", level, empty);
      end
   endtask

   task automatic test_lifo();
      apply_reset();
      do_cmd("push_11", PUSH, 8'h11);
      do_cmd("push_22", PUSH, 8'h22);
      do_cmd("tos_22", TOS, 8'h00);
      do_cmd("nop_hold", NOP, 8'hAA);
      do_cmd("pop_22", POP, 8'h00);
      do_cmd("pop_11", POP, 8'h00);
      checks++;
      if (empty !== 1'b1 || level !== '0) begin
         errors++;
         $display("FAIL lifo_empty: empty=%b level=%0d expected 1 0", empty, level);
      end
   endtask

   task automatic test_overflow();
      apply_reset();
      for (int i = 1; i <= DEPTH; i++) do_cmd("push_fill", PUSH, DATA_W'(i));
      checks++;
      if (full !== 1'b1 || level !== LW'(DEPTH)) begin
         errors++;
         $display("FAIL fill_full: full=%b level=%0d expected 1 %0d", full, level, DEPTH);
      end
      do_cmd("push_over", PUSH, 8'hFF);
      do_cmd("pop_after_over", POP, 8'h00);
   endtask

   task automatic test_underflow();
      apply_reset();
      do_cmd("pop_empty", POP, 8'h00);
      do_cmd("tos_empty", TOS, 8'h00);
      do_cmd("push_after_under", PUSH, 8'h5C);
      do_cmd("tos_after_under", TOS, 8'h00);
   endtask

   task automatic test_reset_midflight();
      int pulses;
      apply_reset();
      do_cmd("push_a", PUSH, 8'h01);
      do_cmd("push_b", PUSH, 8'h02);
      cmd_valid = 1'b1;
      cmd_op    = PUSH;
      cmd_data  = 8'h55;
      @(posedge clk);
      #1 cmd_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      model_reset();
      #1;
      checks++;
      if (level !== '0 || rsp_valid !== 1'b0) begin
         errors++;
         $display("FAIL midflight_async: level=%0d rsp_valid=%b expected 0 0", level, rsp_valid);
      end
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         if (rsp_valid === 1'b1) pulses++;
      end
      checks++;
      if (pulses != 0 || cmd_ready !== 1'b1 || level !== '0) begin
         errors++;
         $display("FAIL midflight_discard: pulses=%0d cmd_ready=%b level=%0d expected 0 1 0", pulses, cmd_ready, level);
      end
   endtask

   task automatic test_back_to_back();
      int accepted;
      int pulses;
      apply_reset();
      accepted = 0;
      pulses   = 0;
      for (int i = 0; i < 6; i++) begin
         if (rsp_valid === 1'b1) begin pulses++; compare_rsp("b2b"); end
         cmd_valid = 1'b1;
         cmd_op    = PUSH;
         cmd_data  = DATA_W'(8'h40 + i);
         if (cmd_ready === 1'b1) begin
            accepted++;
            model_cmd(PUSH, cmd_data);
         end
         @(negedge clk);
      end
      cmd_valid = 1'b0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid === 1'b1) begin pulses++; compare_rsp("b2b"); end
         @(negedge clk);
      end
      checks++;
      if (accepted != 2 || pulses != 2 || level !== LW'(2)) begin
         errors++;
         $display("FAIL b2b_count: accepted=%0d pulses=%0d level=%0d expected 2 2 2", accepted, pulses, level);
      end
      do_cmd("b2b_tos", TOS, 8'h00);
   endtask

   initial begin
      model_reset();
      test_reset();
      test_push_latency();
      test_lifo();
      test_overflow();
      test_underflow();
      test_reset_midflight();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/stack_ctrl.md
STACK_CTRL -- requirements
Module: stack_ctrl

Interface
REQ-001 SHALL provide parameter: DATA_W, 8, data word width.
REQ-002 SHALL provide parameter: DEPTH, 8, stack entries; power of two, >=2.
REQ-003 SHALL provide port: clk  input  1  single clock, rising-edge.
REQ-004 SHALL provide port: rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL provide port: cmd_valid  input  1  command offered.
REQ-006 SHALL provide port: cmd_ready  output  1  block accepts a command this cycle.
REQ-007 SHALL provide port: cmd_op  input  2  00 NOP, 01 PUSH, 10 POP, 11 TOS (peek).
REQ-008 SHALL provide port: cmd_data  input  DATA_W  PUSH operand.
REQ-009 SHALL provide port: rsp_valid  output  1  one-cycle completion pulse.
REQ-010 SHALL provide port: rsp_data  output  DATA_W  popped/peeked word.
REQ-011 SHALL provide ports: full  output  1;  empty  output  1.
REQ-012 SHALL provide port: level  output  $clog2(DEPTH)+1  current entry count.
REQ-013 SHALL provide port: err  output  1  sticky overflow/underflow flag.

Function
REQ-014 FSM SHALL have states IDLE, EXEC, RESP: IDLE->EXEC on cmd_valid&&cmd_ready; EXEC->RESP; RESP->IDLE unconditionally.
REQ-015 cmd_ready SHALL be 1 only in IDLE; cmd_valid outside IDLE is ignored.
REQ-016 cmd_op and cmd_data SHALL be registered at acceptance; later input changes have no effect on the in-flight command.
REQ-017 At the EXEC edge: PUSH writes mem[sp], sp+1; POP captures mem[sp-1], sp-1; TOS captures mem[sp-1], sp unchanged; NOP does nothing.
REQ-018 In RESP, rsp_valid SHALL be 1 for exactly one cycle; rsp_data holds its value until the next POP/TOS capture.
REQ-019 Latency: accept at edge N, rsp_valid high in cycle N+2, cmd_ready high again in cycle N+3; throughput one command per 3 cycles.
REQ-020 sp SHALL be $clog2(DEPTH)+1 bits, range 0..DEPTH, never wrapping; level = sp.
REQ-021 full = (level==DEPTH), empty = (level==0), decoded from registered sp.
REQ-022 PUSH while full, POP/TOS while empty SHALL be illegal: no sp change, no memory write, rsp_data captured as 0.
REQ-023 Illegal and NOP commands SHALL still produce the rsp_valid pulse.

Reset
REQ-024 rst SHALL force, asynchronously: state IDLE, sp 0, rsp_valid 0, rsp_data 0, err 0; hence cmd_ready 1, empty 1, full 0, level 0.
REQ-025 Stack memory contents SHALL NOT be reset.
REQ-026 rst during EXEC or RESP SHALL discard the in-flight command; no rsp_valid follows.

Configuration
REQ-027 Macro STACK_ERR_TRAP_EN defined: an illegal command SHALL set err (sticky until rst); while err=1 every command completes as NOP with rsp_data 0.
REQ-028 STACK_ERR_TRAP_EN undefined: err SHALL be tied 0; illegal commands behave per REQ-022 only, and subsequent commands execute normally.

Structure
REQ-029 Package stack_pkg SHALL hold the cmd_op encodings, FSM state encoding and default DATA_W/DEPTH constants.
REQ-030 Sub-module stack_mem SHALL implement DEPTH x DATA_W storage: one synchronous write port, one asynchronous read port, no reset.

Verification
REQ-031 After reset, PUSH 0x3A: cmd_ready low 2 cycles, rsp_valid at N+2, level 1, empty 0.
REQ-032 PUSH 0x11, PUSH 0x22, TOS -> rsp_data 0x22, level 2; POP -> 0x22; POP -> 0x11, empty 1.
REQ-033 PUSH 0x01..0x08 -> full 1, level 8; PUSH 0xFF -> level 8, err 1 (macro) / 0 (no macro); then POP -> 0x08 (no macro) / 0x00 (macro).
REQ-034 POP on empty -> rsp_valid pulse, rsp_data 0x00, level 0, err per macro.
REQ-035 Two PUSHes, then rst asserted during EXEC of PUSH 0x55 -> level 0, no rsp_valid, cmd_ready 1 after release.
REQ-036 cmd_valid held high with PUSH for 6 cycles from IDLE -> exactly two acceptances, level 2.
